id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-select stage for the execute unit. Captures decoded instruction fields on each clock, resolves RAW hazards by forwarding from the MEM and WB stages, and drives the ALU's `a`, `b` and `alu_select` inputs directly. Detects load-use hazards and inserts a one-cycle bubble, requesting an upstream stall.

---
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Feeds the ALU operands and opcode directly; contains no arithmetic of its own.
module id_ex_stage #(
  parameter int N    = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [N-1:0]    id_pc,
  input  logic [N-1:0]    id_rs1_data,
  input  logic [N-1:0]    id_rs2_data,
  input  logic [N-1:0]    id_imm,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            id_a_sel,
  input  logic            id_b_sel,
  input  logic [3:0]      id_alu_select,
  input  logic            stall,
  input  logic            flush,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            mem_reg_write,
  input  logic            wb_reg_write,
  input  logic [N-1:0]    mem_result,
  input  logic [N-1:0]    wb_result,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [3:0]      alu_select,
  output logic [N-1:0]    ex_store_data,
  output logic [N-1:0]    ex_pc,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_is_load
);

  logic [N-1:0]    rs1_data_q, rs2_data_q, imm_q;
  logic [RA_W-1:0] rs1_addr_q, rs2_addr_q;
  logic            a_sel_q, b_sel_q;
  logic [N-1:0]    fwd_rs1, fwd_rs2;
  logic            rs1_match, rs2_match;
  logic            bubble;

  assign rs1_match = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_match = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  assign hazard_stall = ex_valid && ex_is_load && (ex_rd_addr != '0) && id_valid
                        && (rs1_match || rs2_match);

  // Flush outranks stall; a load-use hazard only bubbles when not held.
  assign bubble = flush || (!stall && hazard_stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      a_sel_q      <= 1'b0;
      b_sel_q      <= 1'b0;
      alu_select   <= '0;
    end else if (bubble) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      ex_rd_addr   <= '0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      a_sel_q      <= 1'b0;
      b_sel_q      <= 1'b0;
      alu_select   <= '0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      rs1_data_q   <= id_rs1_data;
      rs2_data_q   <= id_rs2_data;
      imm_q        <= id_imm;
      rs1_addr_q   <= id_rs1_addr;
      rs2_addr_q   <= id_rs2_addr;
      ex_rd_addr   <= id_rd_addr;
      ex_reg_write <= id_reg_write && id_valid;
      ex_is_load   <= id_is_load && id_valid;
      a_sel_q      <= id_a_sel;
      b_sel_q      <= id_b_sel;
      alu_select   <= id_alu_select;
    end
  end

  // MEM holds the younger result, so it wins over WB; x0 is hardwired zero.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (rs1_addr_q != '0 && mem_reg_write && mem_rd_addr == rs1_addr_q)
      fwd_rs1 = mem_result;
    else if (rs1_addr_q != '0 && wb_reg_write && wb_rd_addr == rs1_addr_q)
      fwd_rs1 = wb_result;

    fwd_rs2 = rs2_data_q;
    if (rs2_addr_q != '0 && mem_reg_write && mem_rd_addr == rs2_addr_q)
      fwd_rs2 = mem_result;
    else if (rs2_addr_q != '0 && wb_reg_write && wb_rd_addr == rs2_addr_q)
      fwd_rs2 = wb_result;
  end

  assign alu_a         = a_sel_q ? ex_pc : fwd_rs1;
  assign alu_b         = b_sel_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a slot-level model.
module tb_id_ex_stage;
  localparam int N = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load, id_a_sel, id_b_sel;
  logic [N-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
  logic [RA_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr, mem_rd_addr, wb_rd_addr;
  logic [3:0] id_alu_select;
  logic stall, flush, mem_reg_write, wb_reg_write;
  logic hazard_stall, ex_valid, ex_reg_write, ex_is_load;
  logic [N-1:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0] alu_select;
  logic [RA_W-1:0] ex_rd_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = clk_en ? ~clk : 1'b0;

  id_ex_stage #(.N(N), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_alu_select(id_alu_select), .stall(stall), .flush(flush),
    .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_result(mem_result), .wb_result(wb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_select(alu_select), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
  );

  // Reference model: the instruction currently occupying the EX slot.
  typedef struct packed {
    logic v;
    logic [N-1:0] pc, d1, d2, imm;
    logic [RA_W-1:0] a1, a2, rd;
    logic rw, ld, as, bs;
    logic [3:0] op;
  } slot_t;
  slot_t m;

  function automatic logic [N-1:0] fwd(input logic [RA_W-1:0] a, input logic [N-1:0] d);
    if (a == 0) return d;
    if (mem_reg_write && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return d;
  endfunction

  function automatic logic model_hazard();
    if (!(m.v && m.ld && m.rd != 0 && id_valid)) return 1'b0;
    return (id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd);
  endfunction

  function automatic slot_t model_next();
    slot_t s;
    if (flush) return '0;
    if (stall) return m;
    if (model_hazard()) return '0;
    s.v = id_valid; s.pc = id_pc; s.d1 = id_rs1_data; s.d2 = id_rs2_data; s.imm = id_imm;
    s.a1 = id_rs1_addr; s.a2 = id_rs2_addr; s.rd = id_rd_addr;
    s.rw = id_reg_write; s.ld = id_is_load; s.as = id_a_sel; s.bs = id_b_sel;
    s.op = id_alu_select;
    return s;
  endfunction

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_reg_write = 0; id_is_load = 0; id_a_sel = 0; id_b_sel = 0; id_alu_select = 0;
    stall = 0; flush = 0; mem_rd_addr = 0; wb_rd_addr = 0; mem_reg_write = 0;
    wb_reg_write = 0; mem_result = 0; wb_result = 0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if ({hazard_stall, ex_valid, ex_reg_write, ex_is_load, alu_select} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_flags: got %b, want 00000000",
               {hazard_stall, ex_valid, ex_reg_write, ex_is_load, alu_select});
    end
    n_cmp++;
    if ({alu_a, alu_b, ex_store_data, ex_pc} !== '0) begin
      n_err++;
      $display("FAIL reset_data: a=%h b=%h sd=%h pc=%h, want all 0", alu_a, alu_b, ex_store_data, ex_pc);
    end
    #2 rst = 1'b0;
    clk_en = 1'b1;
    advance();
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    id_valid = 1; id_rs1_addr = 5; id_rs2_addr = 6; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_rs1_data = 1; id_rs2_data = 2; id_rd_addr = 8; id_reg_write = 1;
    advance();
    idle_inputs();
    mem_reg_write = 1; mem_rd_addr = 5; mem_result = 32'h10;
    wb_reg_write = 1; wb_rd_addr = 5; wb_result = 32'h20;
    #1;
    n_cmp++;
    if (alu_a !== 32'h10) begin n_err++; $display("FAIL fwd_mem_a: got %h, want 00000010", alu_a); end
    n_cmp++;
    if (alu_b !== 32'h2) begin n_err++; $display("FAIL fwd_mem_b: got %h, want 00000002", alu_b); end
    n_cmp++;
    if (alu_select !== 4'd0) begin n_err++; $display("FAIL fwd_mem_op: got %0d, want 0", alu_select); end
    mem_reg_write = 0;
    #1;
    n_cmp++;
    if (alu_a !== 32'h20) begin n_err++; $display("FAIL fwd_wb_a: got %h, want 00000020", alu_a); end
    advance();
  endtask

  task automatic test_x0();
    idle_inputs();
    id_valid = 1; id_uses_rs1 = 1; id_rs1_addr = 0; id_rs1_data = 0;
    advance();
    idle_inputs();
    mem_reg_write = 1; mem_rd_addr = 0; mem_result = 32'hFFFF_FFFF;
    wb_reg_write = 1; wb_rd_addr = 0; wb_result = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (alu_a !== 32'h0) begin n_err++; $display("FAIL x0_no_fwd: got %h, want 00000000", alu_a); end
    advance();
  endtask

  task automatic test_load_use();
    idle_inputs();
    id_valid = 1; id_is_load = 1; id_reg_write = 1; id_rd_addr = 7; id_alu_select = 0;
    advance();
    idle_inputs();
    id_valid = 1; id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_addr = 3; id_rs2_addr = 7;
    id_alu_select = 4'd12; id_reg_write = 1; id_rd_addr = 9;
    #1;
    n_cmp++;
    if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL lu_hazard: got %b, want 1", hazard_stall); end
    advance();
    n_cmp++;
    if ({ex_valid, alu_select} !== 5'b0) begin
      n_err++; $display("FAIL lu_bubble: valid=%b op=%0d, want 0/0", ex_valid, alu_select);
    end
    n_cmp++;
    if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b, want 0", hazard_stall); end
    advance();
    n_cmp++;
    if ({ex_valid, alu_select} !== 5'b11100) begin
      n_err++; $display("FAIL lu_issue: valid=%b op=%0d, want 1/12", ex_valid, alu_select);
    end
  endtask

  task automatic test_flush_over_stall();
    idle_inputs();
    id_valid = 1; id_reg_write = 1; id_rd_addr = 4;
    advance();
    flush = 1; stall = 1;
    advance();
    n_cmp++;
    if ({ex_valid, ex_reg_write} !== 2'b00) begin
      n_err++; $display("FAIL flush_over_stall: valid=%b rw=%b, want 0/0", ex_valid, ex_reg_write);
    end
    idle_inputs();
  endtask

  task automatic test_imm_pc();
    idle_inputs();
    id_valid = 1; id_a_sel = 1; id_b_sel = 1; id_pc = 32'h100; id_imm = 32'h4;
    id_rs2_addr = 3; id_rs2_data = 32'h55; id_uses_rs2 = 1;
    advance();
    idle_inputs();
    mem_reg_write = 1; mem_rd_addr = 3; mem_result = 32'h77;
    #1;
    n_cmp++;
    if ({alu_a, alu_b} !== {32'h100, 32'h4}) begin
      n_err++; $display("FAIL imm_pc_sel: a=%h b=%h, want 00000100/00000004", alu_a, alu_b);
    end
    n_cmp++;
    if (ex_store_data !== 32'h77) begin
      n_err++; $display("FAIL store_fwd: got %h, want 00000077", ex_store_data);
    end
    advance();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    id_valid = 1; id_rs1_data = 32'hDEAD_BEEF; id_rs1_addr = 2; id_pc = 32'h40; id_reg_write = 1;
    advance();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ex_valid, ex_reg_write, alu_a, ex_pc} !== '0) begin
      n_err++; $display("FAIL async_reset: valid=%b rw=%b a=%h pc=%h, want zeros",
                        ex_valid, ex_reg_write, alu_a, ex_pc);
    end
    #1 rst = 1'b0;
    advance();
  endtask

  task automatic test_random();
    slot_t nxt;
    logic exp_h;
    logic [N-1:0] f1, f2, ea, eb;
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    m = '0;
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = RA_W'($urandom_range(0, 3)); id_rs2_addr = RA_W'($urandom_range(0, 3));
      id_rd_addr = RA_W'($urandom_range(0, 3));
      id_uses_rs1 = $urandom_range(0, 1); id_uses_rs2 = $urandom_range(0, 1);
      id_reg_write = $urandom_range(0, 1); id_is_load = ($urandom_range(0, 2) == 0);
      id_a_sel = $urandom_range(0, 1); id_b_sel = $urandom_range(0, 1);
      id_alu_select = 4'($urandom_range(0, 15));
      stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 9) == 0);
      mem_reg_write = $urandom_range(0, 1); wb_reg_write = $urandom_range(0, 1);
      mem_rd_addr = RA_W'($urandom_range(0, 3)); wb_rd_addr = RA_W'($urandom_range(0, 3));
      mem_result = $urandom; wb_result = $urandom;
      #2;
      exp_h = model_hazard();
      f1 = fwd(m.a1, m.d1);
      f2 = fwd(m.a2, m.d2);
      ea = m.as ? m.pc : f1;
      eb = m.bs ? m.imm : f2;
      n_cmp++;
      if (hazard_stall !== exp_h) begin
        n_err++; $display("FAIL rnd_hazard[%0d]: got %b, want %b", i, hazard_stall, exp_h);
      end
      n_cmp++;
      if ({ex_valid, ex_reg_write, ex_is_load} !== {m.v, m.v & m.rw, m.v & m.ld}) begin
        n_err++; $display("FAIL rnd_flags[%0d]: got %b, want %b", i,
                          {ex_valid, ex_reg_write, ex_is_load}, {m.v, m.v & m.rw, m.v & m.ld});
      end
      n_cmp++;
      if ({alu_a, alu_b, ex_store_data} !== {ea, eb, f2}) begin
        n_err++; $display("FAIL rnd_operands[%0d]: a=%h b=%h sd=%h, want %h %h %h",
                          i, alu_a, alu_b, ex_store_data, ea, eb, f2);
      end
      n_cmp++;
      if ({alu_select, ex_pc, ex_rd_addr} !== {m.op, m.pc, m.rd}) begin
        n_err++; $display("FAIL rnd_fields[%0d]: op=%0d pc=%h rd=%0d, want %0d %h %0d",
                          i, alu_select, ex_pc, ex_rd_addr, m.op, m.pc, m.rd);
      end
      nxt = model_next();
      @(posedge clk);
      m = nxt;
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_x0();
    test_load_use();
    test_flush_over_stall();
    test_imm_pc();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
